// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin mux arbiter.
// CNT_W holds the quantum counter (QUANTUM up to 15).
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner: first set bit of v scanning p+1, p+2, ... mod 8.
// Rotate so p+1 lands at bit 0, priority-encode, then add the offset back.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] v,
  input  logic [SEL_W-1:0] p,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   first;

  always_comb begin
    dbl   = {v, v} >> ({1'b0, p} + 4'd1);
    rot   = dbl[N_REQ-1:0];
    first = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = SEL_W'(i);
    end
    idx = p + first + SEL_W'(1);
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux; grant 1 cycle after request, quantum-limited hold.
// Optional ARB_LOCK_EN adds a lock input that lets the holder keep the mux past its quantum.
module mux8_rr_arbiter
  import arb_pkg::*;
#(
  parameter int QUANTUM = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic             y
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_q, y_d;

  logic [N_REQ-1:0]   others;
  logic [N_REQ-1:0]   pick_v;
  logic [SEL_W-1:0]   pick_p;
  logic [SEL_W-1:0]   pick_idx;
  logic               holder_req;
  logic               at_quantum;
  logic               lock_hold;
  logic               release_now;

  assign holder_req = req[sel_q];
  assign others     = req & ~(N_REQ'(1) << sel_q);
  assign at_quantum = (cnt_q == CNT_W'(QUANTUM - 1));

`ifdef ARB_LOCK_EN
  assign lock_hold = lock & holder_req;
`else
  assign lock_hold = 1'b0;
`endif

  assign release_now = !holder_req || (at_quantum && !lock_hold);

  // One picker serves both cases: fresh arbitration from IDLE, or handoff away from the holder.
  assign pick_v = (state_q == GRANT) ? others : req;
  assign pick_p = (state_q == GRANT) ? sel_q : ptr_q;

  rr_pick u_pick (
    .v   (pick_v),
    .p   (pick_p),
    .idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    y_d     = (state_q == GRANT) ? d[sel_q] : 1'b0;

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          sel_d   = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q;
          cnt_d = '0;
          if (others != '0) begin
            sel_d = pick_idx;
          end else if (!holder_req) begin
            state_d = IDLE;
          end
        end else if (!at_quantum) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign sel   = sel_q;
  assign valid = (state_q == GRANT);
  assign grant = valid ? (N_REQ'(1) << sel_q) : '0;
  assign y     = y_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: vector table, directed corner sequences, then random traffic vs a turn-based model.
module tb_mux8_rr_arbiter;

  localparam int QUANTUM = 4;
`ifdef ARB_LOCK_EN
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam bit HAS_LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] d = '0;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       valid;
  logic       y;
`ifdef ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.QUANTUM(QUANTUM)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .d     (d),
`ifdef ARB_LOCK_EN
    .lock  (lock),
`endif
    .sel   (sel),
    .grant (grant),
    .valid (valid),
    .y     (y)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit model_on = 1'b0;

  // Model: who holds the mux, who was served last, and how many cycles of this turn were used.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_held;
  bit m_y;

  function automatic int pick(logic [7:0] v, int p);
    for (int k = 1; k <= 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input logic [7:0] r, input logic [7:0] dd, input bit lk);
    logic [7:0] oth;
    bit hold;
    bit expired;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 7; m_held = 0; m_y = 0;
      return;
    end
    m_y = m_busy ? dd[m_sel] : 1'b0;
    if (!m_busy) begin
      if (r != 0) begin
        m_sel = pick(r, m_ptr); m_busy = 1; m_held = 1;
      end
    end else begin
      hold    = r[m_sel];
      expired = (m_held >= QUANTUM) && !(HAS_LOCK && lk && hold);
      if (!hold || expired) begin
        m_ptr = m_sel;
        oth = r;
        oth[m_sel] = 1'b0;
        if (oth != 0) begin
          m_sel = pick(oth, m_sel); m_held = 1;
        end else if (hold) begin
          m_held = 1;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input bit rst, input logic [7:0] r, input logic [7:0] dd, input bit lk);
    reset = rst;
    req   = r;
    d     = dd;
`ifdef ARB_LOCK_EN
    lock  = lk;
`endif
    @(posedge clk);
    model_step(rst, r, dd, lk);
    #1;
    if (model_on) begin
      chk("rand_sel", int'(sel), m_sel);
      chk("rand_grant", int'(grant), m_busy ? (1 << m_sel) : 0);
      chk("rand_valid", int'(valid), int'(m_busy));
      chk("rand_y", int'(y), int'(m_y));
    end
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] req;
    logic [7:0] d;
    logic [2:0] sel;
    logic [7:0] grant;
    bit         valid;
    bit         y;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rs, logic [7:0] r, logic [7:0] dd, logic [2:0] s,
                              logic [7:0] g, bit v, bit yy);
    vec_t e;
    e.rst = rs; e.req = r; e.d = dd; e.sel = s; e.grant = g; e.valid = v; e.y = yy;
    tbl.push_back(e);
  endfunction

  initial begin
    logic [7:0] rr;
    bit         rs;
    bit         lk;

    // All requesting: 4 cycles each on 0 then 1, then 2; d=AA makes y track odd selects.
    add(1, 8'hFF, 8'hAA, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 8'hAA, 0, 8'h01, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 8'hFF, 8'hAA, 0, 8'h01, 1, 0);
    add(0, 8'hFF, 8'hAA, 1, 8'h02, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 8'hFF, 8'hAA, 1, 8'h02, 1, 1);
    add(0, 8'hFF, 8'hAA, 2, 8'h04, 1, 1);
    add(0, 8'hFF, 8'hAA, 2, 8'h04, 1, 0);
    // Sole requester 5 keeps the grant across quantum expiry, then drops.
    add(1, 8'h20, 8'h20, 0, 8'h00, 0, 0);
    add(0, 8'h20, 8'h20, 5, 8'h20, 1, 0);
    for (int i = 0; i < 9; i++) add(0, 8'h20, 8'h20, 5, 8'h20, 1, 1);
    add(0, 8'h00, 8'h20, 5, 8'h00, 0, 1);
    add(0, 8'h00, 8'h20, 5, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].req, tbl[i].d, 1'b0);
      chk($sformatf("vec%0d_sel", i), int'(sel), int'(tbl[i].sel));
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(tbl[i].grant));
      chk($sformatf("vec%0d_valid", i), int'(valid), int'(tbl[i].valid));
      chk($sformatf("vec%0d_y", i), int'(y), int'(tbl[i].y));
    end

    // Holder 2 drops at cnt=1 while 6 waits: direct handoff, then wrap from 6 back to 2.
    tick(1, 8'h00, 8'h00, 0);
    tick(0, 8'h04, 8'h00, 0);  chk("hand_sel2", int'(sel), 2);
    tick(0, 8'h44, 8'h00, 0);  chk("hand_hold2", int'(sel), 2);
    tick(0, 8'h40, 8'h00, 0);
    chk("hand_sel6", int'(sel), 6);
    chk("hand_valid6", int'(valid), 1);
    chk("hand_grant6", int'(grant), 8'h40);
    for (int i = 0; i < 3; i++) begin
      tick(0, 8'h44, 8'h00, 0); chk("hand_hold6", int'(sel), 6);
    end
    tick(0, 8'h44, 8'h00, 0);  chk("wrap_6to2", int'(sel), 2);

    // Holder 7 with 0 waiting: release wraps to 0.
    tick(1, 8'h00, 8'h00, 0);
    tick(0, 8'h80, 8'h00, 0);  chk("wrap_sel7", int'(sel), 7);
    for (int i = 0; i < 3; i++) begin
      tick(0, 8'h81, 8'h00, 0); chk("wrap_hold7", int'(sel), 7);
    end
    tick(0, 8'h81, 8'h00, 0);
    chk("wrap_7to0_sel", int'(sel), 0);
    chk("wrap_7to0_grant", int'(grant), 8'h01);

    // Data path lag.
    tick(1, 8'h00, 8'h40, 0);
    tick(0, 8'h40, 8'h40, 0);  chk("y_first", int'(y), 0); chk("y_sel6", int'(sel), 6);
    tick(0, 8'h40, 8'h40, 0);  chk("y_lag", int'(y), 1);
    tick(0, 8'h00, 8'h40, 0);  chk("y_last", int'(y), 1); chk("y_idle_valid", int'(valid), 0);
    tick(0, 8'h00, 8'h40, 0);  chk("y_idle", int'(y), 0);

    // Reset mid-grant at cnt=2.
    tick(1, 8'hFF, 8'hFF, 0);
    tick(0, 8'hFF, 8'hFF, 0);
    tick(0, 8'hFF, 8'hFF, 0);
    tick(0, 8'hFF, 8'hFF, 0);
    tick(1, 8'hFF, 8'hFF, 0);
    chk("rst_mid_valid", int'(valid), 0);
    chk("rst_mid_grant", int'(grant), 0);
    chk("rst_mid_y", int'(y), 0);
    chk("rst_mid_sel", int'(sel), 0);
    tick(0, 8'hFF, 8'hFF, 0);  chk("rst_ptr7_sel", int'(sel), 0);

`ifdef ARB_LOCK_EN
    tick(1, 8'h00, 8'h00, 0);
    tick(0, 8'h03, 8'h00, 1);  chk("lock_sel0", int'(sel), 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 8'h03, 8'h00, 1); chk("lock_hold0", int'(sel), 0);
    end
    tick(0, 8'h03, 8'h00, 0);  chk("lock_release", int'(sel), 1);
`endif

    // Random traffic against the model.
    tick(1, 8'h00, 8'h00, 0);
    model_on = 1'b1;
    rr = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rr = 8'($urandom) & 8'($urandom);
      rs = ($urandom_range(0, 149) == 0);
      lk = HAS_LOCK && ($urandom_range(0, 3) == 0);
      tick(rs, rr, 8'($urandom), lk);
    end
    model_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 bit multiplexer among 8 requesters.
- Picks a winner, drives the 3-bit select and a one-hot grant, and enforces a fairness quantum.
- Registers the selected data bit.
- Sits in front of the lab's 8:1 mux/3-to-8 decoder datapath; the select drives the mux, the grant drives requester acknowledge lines.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 (3-bit select).
- SEL_W, 3, select width, log2(N_REQ).
- QUANTUM, 4, maximum consecutive cycles one requester may hold the grant while others wait; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the mux.
- d  input  8  data bits; d[i] belongs to requester i.
- sel  output  3  current mux select (registered).
- grant  output  8  one-hot grant = decode(sel) when valid, else 0.
- valid  output  1  high while in GRANT state.
- y  output  1  registered mux output, d[sel] sampled one cycle earlier.

Behaviour:
- Reset: synchronous, active-high, on clk edge. State=IDLE, sel=0, ptr=7 (so requester 0 has first priority), cnt=0, grant=0, valid=0, y=0. Reset mid-grant aborts the grant on the same edge.
- States: IDLE, GRANT (2-state Moore FSM). grant and valid decode from registers only, never directly from req.
- Winner function pick(v, p): first set bit of v scanning p+1, p+2, … wrapping mod 8. Undefined when v=0; never used in that case.
- IDLE: grant=0, valid=0.
  - On an edge with req≠0: sel<=pick(req, ptr), cnt<=0, go to GRANT.
  - Grant latency is 1 cycle from the request edge.
- GRANT: valid=1, grant=onehot(sel).
  - Release condition: req[sel]=0, or cnt=QUANTUM-1.
  - On release: ptr<=sel. Let others = req with bit sel cleared.
    - If others≠0: sel<=pick(others, sel), cnt<=0, stay in GRANT. Back-to-back handoff, no idle bubble.
    - Else if req[sel]=1 (sole requester, quantum expired): keep sel, cnt<=0, stay in GRANT.
    - Else: go to IDLE.
  - No release: cnt<=cnt+1. cnt is 4 bits and never exceeds QUANTUM-1.
- Request changes:
  - Requests from non-holders never preempt before release.
  - A req drop by the holder releases at the next edge; grant stays asserted 1 cycle after the drop (registered).
- Data path: every edge, y<=(state==GRANT) ? d[sel] : 0. y lags sel by exactly 1 cycle.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,…,7,0 with QUANTUM cycles each.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While in GRANT with lock=1 and req[sel]=1, the quantum expiry is ignored and cnt saturates at QUANTUM-1. A req drop still releases.
- Undefined: port absent; quantum always enforced.

Decomposition:
- Package arb_pkg: state enum {IDLE, GRANT}, N_REQ=8, SEL_W=3, CNT_W=4.
- One sub-module, rr_pick: combinational winner finder with inputs v[7:0] and p[2:0], output idx[2:0], implemented as rotate, priority-encode, un-rotate.
- Top level holds the FSM, ptr, cnt, the sel register and the y register.

Test Plan:
- Reset with req=8'hFF held → after reset deasserts, first edge gives sel=0, grant=8'h01, valid=1. Next QUANTUM(4) cycles rotate sel to 1, then 2.
- Only req[5]=1 for 10 cycles → grant=8'h20 continuously, no gap at quantum expiry. Drop req[5] → grant=0 and valid=0 one edge later.
- req[2] held, req[6] rises mid-grant, then req[2] drops at cnt=1 → next edge sel=6, no IDLE cycle; ptr=2 wraparound verified.
- Holder sel=7, req=8'h81 → at release sel wraps to 0, not 7.
- d=8'b0100_0000 with sel=6 granted → y=1 exactly one cycle after sel=6 appears; y=0 while in IDLE.
- Assert reset mid-GRANT with cnt=2 → next edge state=IDLE, grant=0, y=0, ptr=7. With ARB_LOCK_EN, lock=1 holds grant beyond 4 cycles despite other requests.
